// File: rtl/pic_stream_ctrl.sv
`default_nettype none
// ============================================================================
// pic_stream_ctrl : SD block reader -> RGB565 pixel FIFO -> LCD, UART stepping.
// Optional auto-advance slideshow: define SLIDESHOW_EN.
// Revision 1.0
// ============================================================================
module pic_stream_ctrl #(
    parameter int BLKS_PER_PIC = 300,
    parameter int PIC_COUNT    = 16,
    parameter int BASE_BLK     = 0,
    parameter int FIFO_DEPTH   = 8,
    parameter int SLIDE_TICKS  = 50000000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         periph_rdy,
    output logic                         sd_rd_start,
    output logic [31:0]                  sd_rd_addr,
    input  logic [7:0]                   sd_byte,
    input  logic                         sd_byte_vld,
    input  logic                         sd_blk_done,
    input  logic                         sd_err,
    output logic                         lcd_win_start,
    input  logic                         lcd_busy,
    output logic [15:0]                  lcd_pix,
    output logic                         lcd_pix_vld,
    input  logic                         lcd_pix_rdy,
    input  logic                         swap_bytes,
    input  logic                         op_incr,
    input  logic                         op_decr,
    output logic                         op_ack,
    output logic [$clog2(PIC_COUNT)-1:0] pic_idx,
    output logic                         busy,
    output logic                         err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(PIC_COUNT);
    localparam int BW = $clog2(BLKS_PER_PIC + 1);

    typedef enum logic [3:0] {
        ST_INIT    = 4'd0,
        ST_BLK_RST = 4'd1,
        ST_WIN     = 4'd2,
        ST_WIN_W   = 4'd3,
        ST_REQ     = 4'd4,
        ST_STREAM  = 4'd5,
        ST_BLK_END = 4'd6,
        ST_DRAIN   = 4'd7,
        ST_IDLE    = 4'd8,
        ST_IDX_MOD = 4'd9,
        ST_ERR     = 4'd10
    } state_t;

    generate
        if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || SLIDE_TICKS < 1)
        begin : g_bad_cfg
            $error("pic_stream_ctrl: illegal FIFO_DEPTH or SLIDE_TICKS");
        end
    endgenerate

    state_t          r_state;
    logic [BW-1:0]   r_blk_off;
    logic [1:0]      r_wcnt;
    logic            r_op_armed;
    logic            r_inc;
    logic            r_dec;
`ifdef SLIDESHOW_EN
    logic [31:0]     r_tick;
`endif

    logic [15:0]     r_mem [FIFO_DEPTH];
    logic [AW:0]     r_wptr;
    logic [AW:0]     r_rptr;
    logic            r_phase;
    logic [7:0]      r_b0;

    logic            w_empty;
    logic            w_full;
    logic            w_rd;
    logic            w_wr;
    logic            w_ovf;
    logic            w_wr_ok;
    logic            w_odd_done;
    logic            w_op_any;
    logic [15:0]     w_word;
    logic [31:0]     w_addr;
    logic [31:0]     w_blk_nxt;

    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_rd       = !w_empty && lcd_pix_rdy;
    assign w_wr       = (r_state == ST_STREAM) && sd_byte_vld && r_phase;
    assign w_ovf      = w_wr && w_full && !w_rd;
    assign w_wr_ok    = w_wr && !w_ovf;
    // A byte arriving alongside the done pulse still counts toward the parity.
    assign w_odd_done = (r_state == ST_STREAM) && sd_blk_done && (r_phase ^ sd_byte_vld);
    assign w_op_any   = op_incr || op_decr;
    assign w_word     = swap_bytes ? {sd_byte, r_b0} : {r_b0, sd_byte};
    assign w_addr     = 32'(BASE_BLK) + 32'(pic_idx) * 32'(BLKS_PER_PIC) + 32'(r_blk_off);
    assign w_blk_nxt  = 32'(r_blk_off) + 32'd1;

    assign lcd_pix     = r_mem[r_rptr[AW-1:0]];
    assign lcd_pix_vld = !w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_INIT;
            r_blk_off     <= '0;
            r_wcnt        <= 2'd0;
            r_op_armed    <= 1'b1;
            r_inc         <= 1'b0;
            r_dec         <= 1'b0;
            sd_rd_start   <= 1'b0;
            sd_rd_addr    <= 32'd0;
            lcd_win_start <= 1'b0;
            op_ack        <= 1'b0;
            pic_idx       <= '0;
            busy          <= 1'b0;
            err           <= 1'b0;
`ifdef SLIDESHOW_EN
            r_tick        <= 32'd0;
`endif
        end else begin
            sd_rd_start   <= 1'b0;
            lcd_win_start <= 1'b0;
            op_ack        <= 1'b0;
            busy          <= 1'b1;
`ifdef SLIDESHOW_EN
            r_tick        <= 32'd0;
`endif
            if (!op_incr && !op_decr) begin
                r_op_armed <= 1'b1;
            end
            case (r_state)
                ST_INIT: begin
                    if (periph_rdy) r_state <= ST_BLK_RST;
                end
                ST_BLK_RST: begin
                    r_blk_off <= '0;
                    r_state   <= ST_WIN;
                end
                ST_WIN: begin
                    if (!lcd_busy) begin
                        lcd_win_start <= 1'b1;
                        r_wcnt        <= 2'd0;
                        r_state       <= ST_WIN_W;
                    end
                end
                ST_WIN_W: begin
                    // r_wcnt is 0 in the cycle the pulse is visible.
                    if (r_wcnt != 2'd2) r_wcnt <= r_wcnt + 2'd1;
                    if (r_wcnt == 2'd2 && !lcd_busy) r_state <= ST_REQ;
                end
                ST_REQ: begin
                    sd_rd_start <= 1'b1;
                    sd_rd_addr  <= w_addr;
                    r_state     <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (sd_blk_done) r_state <= ST_BLK_END;
                end
                ST_BLK_END: begin
                    r_blk_off <= r_blk_off + 1'b1;
                    if (w_blk_nxt < 32'(BLKS_PER_PIC)) r_state <= ST_REQ;
                    else                               r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_empty) begin
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (w_op_any && r_op_armed) begin
                        op_ack     <= 1'b1;
                        r_op_armed <= 1'b0;
                        r_inc      <= op_incr;
                        r_dec      <= op_decr;
                        r_state    <= ST_IDX_MOD;
                    end
`ifdef SLIDESHOW_EN
                    else if (r_tick == 32'(SLIDE_TICKS - 1)) begin
                        r_inc   <= 1'b1;
                        r_dec   <= 1'b0;
                        r_state <= ST_IDX_MOD;
                    end
`endif
                    else begin
                        busy <= 1'b0;
`ifdef SLIDESHOW_EN
                        r_tick <= r_tick + 32'd1;
`endif
                    end
                end
                ST_IDX_MOD: begin
                    if (r_inc && !r_dec) begin
                        pic_idx <= (pic_idx == IW'(PIC_COUNT - 1)) ? '0 : pic_idx + 1'b1;
                    end else if (r_dec && !r_inc) begin
                        pic_idx <= (pic_idx == '0) ? IW'(PIC_COUNT - 1) : pic_idx - 1'b1;
                    end
                    r_state <= ST_BLK_RST;
                end
                ST_ERR: begin
                    err <= 1'b1;
                end
                default: r_state <= ST_ERR;
            endcase
            if (sd_err || w_ovf || w_odd_done) begin
                r_state <= ST_ERR;
                err     <= 1'b1;
                busy    <= 1'b1;
                op_ack  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_phase <= 1'b0;
            r_b0    <= 8'd0;
        end else if (r_state == ST_ERR) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_phase <= 1'b0;
        end else begin
            if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
            if (w_rd)    r_rptr <= r_rptr + 1'b1;
            if (r_state != ST_STREAM) begin
                r_phase <= 1'b0;
            end else if (sd_byte_vld) begin
                r_phase <= ~r_phase;
                if (!r_phase) r_b0 <= sd_byte;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[r_wptr[AW-1:0]] <= w_word;
    end

endmodule
`default_nettype wire
